task3_shift: RTL and testbench

- 8-bit LED shift register driven by two active-low push-buttons and two slide switches; board-level top block for the shift exercise.
- key1 press: shift right, sw1 bit enters at MSB. key2 press: shift left, sw0 bit enters at LSB.
- Exactly one shift per button press, independent of how long the button is held.

---
 rtl/task3_shift.sv | 167 ++++++++++++++++
 tb/tb_task3_shift.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/task3_shift.sv
// -----------------------------------------------------------------------------
// task3_shift
//   Board-level LED shift register driven by two active-low push-buttons.
//   key1 press shifts right (sw1 enters at MSB); key2 press shifts left
//   (sw0 enters at LSB). Exactly one shift per press, however long it is held.
//
//   Optional build macro: TASK3_SHIFT_DEBOUNCE_EN
//     When defined, each synchronized key passes through a counter-based
//     debouncer before edge detection, adding DEBOUNCE_CYCLES of latency.
//
//   Reset (key0_rst) is synchronous and active-high.
// -----------------------------------------------------------------------------
module task3_shift #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             key0_rst,
    input  logic             key1_rshift,
    input  logic             key2_lshift,
    input  logic             sw1_rshift,
    input  logic             sw0_lshift,
    output logic [WIDTH-1:0] ledr
);

    // Index of each key inside the packed per-key vectors below.
    localparam int KEY_R    = 0;
    localparam int KEY_L    = 1;
    localparam int NUM_KEYS = 2;

    typedef enum logic [1:0] {
        SHIFT_NONE  = 2'd0,
        SHIFT_RIGHT = 2'd1,
        SHIFT_LEFT  = 2'd2
    } shift_cmd_e;

    // A single flop is not a synchronizer; refuse to elaborate below two.
    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync_stages
            $error("task3_shift: SYNC_STAGES must be at least 2");
        end
    endgenerate

    logic [NUM_KEYS-1:0]                  key_raw;
    logic [NUM_KEYS-1:0][SYNC_STAGES-1:0] key_sync_q;
    logic [SYNC_STAGES-1:0]               sw1_sync_q;
    logic [SYNC_STAGES-1:0]               sw0_sync_q;
    logic [NUM_KEYS-1:0]                  key_sync;
    logic [NUM_KEYS-1:0]                  key_level;
    logic [NUM_KEYS-1:0]                  key_prev_q;
    logic [NUM_KEYS-1:0]                  press;
    logic                                 sw1_sync;
    logic                                 sw0_sync;
    shift_cmd_e                           shift_cmd;
    logic [WIDTH-1:0]                     ledr_next;

    assign key_raw = {key2_lshift, key1_rshift};

    // Key synchronizers; reset to the released level so nothing looks pressed.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its neighbour, which is what makes the
        // chain a chain rather than a single flop.
        if (key0_rst) begin
            key_sync_q <= '1;
        end else begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                key_sync_q[k] <= {key_sync_q[k][SYNC_STAGES-2:0], key_raw[k]};
            end
        end
    end

    // Switch synchronizers, same depth as the keys so each switch is sampled
    // in step with the key that consumes it.
    always_ff @(posedge clk) begin
        if (key0_rst) begin
            sw1_sync_q <= '0;
            sw0_sync_q <= '0;
        end else begin
            sw1_sync_q <= {sw1_sync_q[SYNC_STAGES-2:0], sw1_rshift};
            sw0_sync_q <= {sw0_sync_q[SYNC_STAGES-2:0], sw0_lshift};
        end
    end

    assign key_sync = {key_sync_q[KEY_L][SYNC_STAGES-1],
                       key_sync_q[KEY_R][SYNC_STAGES-1]};
    assign sw1_sync = sw1_sync_q[SYNC_STAGES-1];
    assign sw0_sync = sw0_sync_q[SYNC_STAGES-1];

`ifdef TASK3_SHIFT_DEBOUNCE_EN
    // Counter just wide enough to hold DEBOUNCE_CYCLES.
    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [NUM_KEYS-1:0][CNT_W-1:0] db_cnt_q;
    logic [NUM_KEYS-1:0]            db_level_q;

    // Debouncer: the level follows the key only after DEBOUNCE_CYCLES
    // consecutive disagreeing samples; any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (key0_rst) begin
            db_level_q <= '1;
            db_cnt_q   <= '0;
        end else begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (key_sync[k] == db_level_q[k]) begin
                    db_cnt_q[k] <= '0;
                end else if (db_cnt_q[k] == CNT_LAST) begin
                    db_level_q[k] <= key_sync[k];
                    db_cnt_q[k]   <= '0;
                end else begin
                    db_cnt_q[k] <= db_cnt_q[k] + CNT_ONE;
                end
            end
        end
    end

    assign key_level = db_level_q;
`else
    assign key_level = key_sync;
`endif

    // Previous key level for falling-edge detection; released after reset.
    always_ff @(posedge clk) begin
        if (key0_rst) begin
            key_prev_q <= '1;
        end else begin
            key_prev_q <= key_level;
        end
    end

    // A press is a released-to-pressed transition: one pulse per press.
    assign press = key_prev_q & ~key_level;

    // Decode pulses into a shift command and compute the next register value.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; a missed
        // branch would otherwise infer a latch.
        shift_cmd = SHIFT_NONE;
        ledr_next = ledr;

        // Both pulses together cancel: the register holds.
        unique case (press)
            2'b01:   shift_cmd = SHIFT_RIGHT;
            2'b10:   shift_cmd = SHIFT_LEFT;
            default: shift_cmd = SHIFT_NONE;
        endcase

        case (shift_cmd)
            SHIFT_RIGHT: ledr_next = {sw1_sync, ledr[WIDTH-1:1]};
            SHIFT_LEFT:  ledr_next = {ledr[WIDTH-2:0], sw0_sync};
            default:     ledr_next = ledr;
        endcase
    end

    // LED register; reset wins over a shift in the same cycle.
    always_ff @(posedge clk) begin
        if (key0_rst) begin
            ledr <= '0;
        end else begin
            ledr <= ledr_next;
        end
    end

endmodule

// File: tb/tb_task3_shift.sv
// -----------------------------------------------------------------------------
// tb_task3_shift
//   Directed self-checking bench for task3_shift with default parameters.
//   Honours TASK3_SHIFT_DEBOUNCE_EN to adjust latency and add a glitch test.
// -----------------------------------------------------------------------------
module tb_task3_shift;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
`ifdef TASK3_SHIFT_DEBOUNCE_EN
    localparam int LAT = SYNC + DEB + 1;
`else
    localparam int LAT = SYNC + 1;
`endif

    logic       clk = 1'b0;
    logic       key0_rst = 1'b0;
    logic       key1_rshift = 1'b1;
    logic       key2_lshift = 1'b1;
    logic       sw1_rshift = 1'b0;
    logic       sw0_lshift = 1'b0;
    logic [7:0] ledr;

    int n_checks = 0;
    int n_errors = 0;

    task3_shift #(
        .WIDTH          (8),
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk        (clk),
        .key0_rst   (key0_rst),
        .key1_rshift(key1_rshift),
        .key2_lshift(key2_lshift),
        .sw1_rshift (sw1_rshift),
        .sw0_lshift (sw0_lshift),
        .ledr       (ledr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 8'h%02h expected 8'h%02h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        key0_rst = 1'b1;
        cycles(2);
        key0_rst = 1'b0;
    endtask

    // which: 1 = key1, 2 = key2, 3 = both on the same edge.
    task automatic press(input int which, input int hold);
        @(negedge clk);
        if (which[0]) key1_rshift = 1'b0;
        if (which[1]) key2_lshift = 1'b0;
        cycles(hold);
        key1_rshift = 1'b1;
        key2_lshift = 1'b1;
        cycles(LAT + 2);
    endtask

    initial begin
        logic [5:0] lbits;

        // Reset with both keys released.
        do_reset();
        check("reset", ledr, 8'h00);
        cycles(8);
        check("post_reset_idle", ledr, 8'h00);

        // First right press with exact latency check.
        sw1_rshift = 1'b1;
        @(negedge clk);
        key1_rshift = 1'b0;
        repeat (LAT - 1) @(posedge clk);
        #1 check("latency_before", ledr, 8'h00);
        @(posedge clk);
        #1 check("latency_at", ledr, 8'h80);
        cycles(2);
        key1_rshift = 1'b1;
        cycles(LAT + 2);
        check("right_1", ledr, 8'h80);
        press(1, LAT + 2);
        check("right_2", ledr, 8'hC0);

        // Left shifts; first one drops the MSB.
        sw0_lshift = 1'b1;
        press(2, LAT + 2);
        check("left_1", ledr, 8'h81);
        press(2, LAT + 2);
        check("left_2", ledr, 8'h03);
        press(2, LAT + 2);
        check("left_3", ledr, 8'h07);

        // Hold key1 for 20 cycles from zero: only one shift.
        do_reset();
        check("reset_2", ledr, 8'h00);
        sw1_rshift = 1'b1;
        @(negedge clk);
        key1_rshift = 1'b0;
        cycles(20);
        check("hold_low", ledr, 8'h80);
        key1_rshift = 1'b1;
        cycles(LAT + 4);
        check("hold_release", ledr, 8'h80);

        // Fill with ones, then insert a zero at the MSB.
        for (int i = 0; i < 7; i++) press(1, LAT + 2);
        check("fill_ff", ledr, 8'hFF);
        sw1_rshift = 1'b0;
        press(1, LAT + 2);
        check("zero_insert", ledr, 8'h7F);

        // Switch activity alone never moves the register.
        for (int i = 0; i < 4; i++) begin
            sw1_rshift = ~sw1_rshift;
            sw0_lshift = ~sw0_lshift;
            cycles(3);
        end
        check("switch_only", ledr, 8'h7F);

        // Build 8'h3C with left shifts (LSB-in order 1,1,1,1,0,0).
        do_reset();
        lbits = 6'b111100;
        for (int i = 5; i >= 0; i--) begin
            sw0_lshift = lbits[i];
            press(2, LAT + 2);
        end
        check("build_3c", ledr, 8'h3C);

        // Both keys on the same edge: hold.
        sw1_rshift = 1'b1;
        sw0_lshift = 1'b1;
        press(3, LAT + 2);
        check("simultaneous", ledr, 8'h3C);

        // Reset on the same edge that would apply a shift.
        @(negedge clk);
        key1_rshift = 1'b0;
        cycles(LAT - 1);
        key0_rst    = 1'b1;
        key1_rshift = 1'b1;
        cycles(2);
        key0_rst = 1'b0;
        check("reset_priority", ledr, 8'h00);
        cycles(LAT + 4);
        check("reset_priority_after", ledr, 8'h00);

`ifdef TASK3_SHIFT_DEBOUNCE_EN
        // Glitch shorter than the debounce window is ignored.
        press(1, DEB - 1);
        check("glitch_ignored", ledr, 8'h00);
        press(1, DEB + 2);
        check("debounced_press", ledr, 8'h80);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end

endmodule
